// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, FSM state encoding and shared constants for the multiply/divide unit
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NOP   = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8,
        MDU_MADD  = 4'd9,
        MDU_MADDU = 4'd10,
        MDU_MSUB  = 4'd11,
        MDU_MSUBU = 4'd12
    } mdu_op_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    // every bit of LO is set on a divide by zero
    localparam logic DIV0_FILL = 1'b1;

endpackage

// File: rtl/mdu_core.sv
// mdu_core: combinational mult/div/madd datapath with divide-by-zero and overflow cases (MDU_MADD_EN adds MADD/MSUB)
module mdu_core
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       mdu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int W2 = 2 * WIDTH;

    logic [W2-1:0]    prod_s, prod_u;
    logic [WIDTH-1:0] abs_a, abs_b, mag_q, mag_r, sq, sr, min_int;
    logic             b_zero, s_ovf;

    // products are formed at full 2*WIDTH, so sign extension yields the exact signed result
    assign prod_s  = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign prod_u  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign min_int = {1'b1, {(WIDTH-1){1'b0}}};
    assign b_zero  = (b == '0);
    assign s_ovf   = (a == min_int) && (b == '1);

    // signed divide through magnitudes: quotient truncates to zero, remainder follows the dividend
    assign abs_a = a[WIDTH-1] ? -a : a;
    assign abs_b = b[WIDTH-1] ? -b : b;
    assign mag_q = b_zero ? '0 : abs_a / abs_b;
    assign mag_r = b_zero ? '0 : abs_a % abs_b;
    assign sq    = (a[WIDTH-1] ^ b[WIDTH-1]) ? -mag_q : mag_q;
    assign sr    = a[WIDTH-1] ? -mag_r : mag_r;

    // result select; ops without a result pass HI/LO through
    always_comb begin
        {res_hi, res_lo} = {hi, lo};
        case (mdu_op)
            MDU_MULT:  {res_hi, res_lo} = prod_s;
            MDU_MULTU: {res_hi, res_lo} = prod_u;
            MDU_DIV:   {res_hi, res_lo} = b_zero ? {a, {WIDTH{DIV0_FILL}}} :
                                          s_ovf  ? {{WIDTH{1'b0}}, min_int} : {sr, sq};
            MDU_DIVU:  {res_hi, res_lo} = b_zero ? {a, {WIDTH{DIV0_FILL}}} :
                                          {(b_zero ? '0 : a % b), (b_zero ? '0 : a / b)};
`ifdef MDU_MADD_EN
            MDU_MADD:  {res_hi, res_lo} = {hi, lo} + prod_s;
            MDU_MADDU: {res_hi, res_lo} = {hi, lo} + prod_u;
            MDU_MSUB:  {res_hi, res_lo} = {hi, lo} - prod_s;
            MDU_MSUBU: {res_hi, res_lo} = {hi, lo} - prod_u;
`endif
            default:   {res_hi, res_lo} = {hi, lo};
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit owning HI/LO (MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU)
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       mdu_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    mdu_state_e       state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [WIDTH-1:0] res_hi, res_lo, res_hi_d, res_lo_d, hi_d, lo_d;
    logic [WIDTH-1:0] core_hi, core_lo;
    logic             is_mul, is_div;

`ifdef MDU_MADD_EN
    assign is_mul = mdu_op inside {MDU_MULT, MDU_MULTU, MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU};
`else
    assign is_mul = mdu_op inside {MDU_MULT, MDU_MULTU};
`endif
    assign is_div = mdu_op inside {MDU_DIV, MDU_DIVU};
    assign busy   = (state == MDU_BUSY);

    mdu_core #(.WIDTH(WIDTH)) u_core (
        .mdu_op (mdu_op),
        .a      (op_a),
        .b      (op_b),
        .hi     (hi),
        .lo     (lo),
        .res_hi (core_hi),
        .res_lo (core_lo)
    );

    // state, counter, shadow result and architectural HI/LO registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= MDU_IDLE;
            cnt    <= '0;
            res_hi <= '0;
            res_lo <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            res_hi <= res_hi_d;
            res_lo <= res_lo_d;
            hi     <= hi_d;
            lo     <= lo_d;
        end
    end

    // launch latches the result up front; BUSY only counts down and commits on the last cycle
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        res_hi_d = res_hi;
        res_lo_d = res_lo;
        hi_d     = hi;
        lo_d     = lo;
        if (state == MDU_IDLE) begin
            if (start && (is_mul || is_div)) begin
                state_d  = MDU_BUSY;
                cnt_d    = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                res_hi_d = core_hi;
                res_lo_d = core_lo;
            end else if (start && mdu_op == MDU_MTHI) begin
                hi_d = op_a;
            end else if (start && mdu_op == MDU_MTLO) begin
                lo_d = op_a;
            end
        end else begin
            cnt_d = cnt - CW'(1);
            if (cnt == CW'(1)) begin
                state_d = MDU_IDLE;
                hi_d    = res_hi;
                lo_d    = res_lo;
            end
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: randomized self-checking bench for mdu_unit against an arithmetic reference model
module tb_mdu_unit;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  mdu_op = 4'd0;
    logic [31:0] op_a = '0, op_b = '0;
    logic        busy;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;
    logic [31:0] mhi = '0, mlo = '0;

    mdu_unit #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mdu_op (mdu_op),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (reset && start && busy)
            assert (!(mdu_op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU,
                                     MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU}))
            else $error("launch op issued while busy");

    task automatic ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
        longint sa, sb, q, r;
        logic [63:0] acc, ps, pu;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        acc = {mhi, mlo};
        ps  = 64'(sa * sb);
        pu  = {32'd0, a} * {32'd0, b};
        lat = 0;
        case (op)
            MDU_MULT:  begin {mhi, mlo} = ps; lat = MC; end
            MDU_MULTU: begin {mhi, mlo} = pu; lat = MC; end
            MDU_DIV: begin
                lat = DC;
                if (b == 0) {mhi, mlo} = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) {mhi, mlo} = {32'd0, 32'h80000000};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    mhi = r[31:0];
                    mlo = q[31:0];
                end
            end
            MDU_DIVU: begin
                lat = DC;
                if (b == 0) {mhi, mlo} = {a, 32'hFFFFFFFF};
                else begin
                    mhi = a % b;
                    mlo = a / b;
                end
            end
            MDU_MTHI: mhi = a;
            MDU_MTLO: mlo = a;
`ifdef MDU_MADD_EN
            MDU_MADD:  begin {mhi, mlo} = acc + ps; lat = MC; end
            MDU_MADDU: begin {mhi, mlo} = acc + pu; lat = MC; end
            MDU_MSUB:  begin {mhi, mlo} = acc - ps; lat = MC; end
            MDU_MSUBU: begin {mhi, mlo} = acc - pu; lat = MC; end
`endif
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string nm);
        logic [31:0] ohi, olo;
        int lat, n;
        ohi = mhi;
        olo = mlo;
        ref_op(op, a, b, lat);
        @(negedge clk);
        start = 1'b1; mdu_op = op; op_a = a; op_b = b;
        @(negedge clk);
        start = 1'b0; mdu_op = MDU_NOP;
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            checks++;
            if (hi !== ohi || lo !== olo) begin
                failures++;
                $display("FAIL %s hold cyc%0d: hi=%h lo=%h expected hi=%h lo=%h", nm, n + 1, hi, lo, ohi, olo);
            end
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== lat) begin failures++; $display("FAIL %s latency: got %0d expected %0d", nm, n, lat); end
        checks++;
        if (hi !== mhi) begin failures++; $display("FAIL %s hi: got %h expected %h", nm, hi, mhi); end
        checks++;
        if (lo !== mlo) begin failures++; $display("FAIL %s lo: got %h expected %h", nm, lo, mlo); end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #3;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %b expected 0", busy); end
        checks++;
        if (hi !== 32'd0) begin failures++; $display("FAIL reset hi: got %h expected 0", hi); end
        checks++;
        if (lo !== 32'd0) begin failures++; $display("FAIL reset lo: got %h expected 0", lo); end
        @(negedge clk);
        reset = 1'b1;
        mhi = '0;
        mlo = '0;
    endtask

    task automatic test_mult();
        run_op(MDU_MULT, -32'sd3, 32'd7, "mult_neg3x7");
        run_op(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
        run_op(MDU_MULT, 32'h80000000, 32'h80000000, "mult_min");
    endtask

    task automatic test_div();
        run_op(MDU_DIVU, 32'd100, 32'd7, "divu_100_7");
        run_op(MDU_DIV, -32'sd7, 32'd2, "div_neg7_2");
        run_op(MDU_DIV, 32'd7, -32'sd2, "div_7_neg2");
        run_op(MDU_DIV, 32'd5, 32'd0, "div_by0");
        run_op(MDU_DIVU, 32'hABCD1234, 32'd0, "divu_by0");
        run_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    endtask

    task automatic test_mt();
        logic [31:0] olo;
        int lat, n;
        run_op(MDU_MTHI, 32'hDEAD, 32'd0, "mthi");
        run_op(MDU_MTLO, 32'hBEEF, 32'd0, "mtlo");
        run_op(MDU_MFHI, 32'h1234, 32'd0, "mfhi_nop");
        olo = mlo;
        ref_op(MDU_MULT, 32'd6, 32'd9, lat);
        @(negedge clk);
        start = 1'b1; mdu_op = MDU_MULT; op_a = 32'd6; op_b = 32'd9;
        @(negedge clk);
        start = 1'b0; mdu_op = MDU_NOP;
        @(negedge clk);
        start = 1'b1; mdu_op = MDU_MTLO; op_a = 32'h5555AAAA;
        @(negedge clk);
        start = 1'b0; mdu_op = MDU_NOP;
        checks++;
        if (lo !== olo) begin failures++; $display("FAIL mtlo_busy lo: got %h expected %h", lo, olo); end
        n = 0;
        while (busy === 1'b1 && n < 64) begin n++; @(negedge clk); end
        checks++;
        if (lo !== mlo) begin failures++; $display("FAIL mtlo_busy commit lo: got %h expected %h", lo, mlo); end
        checks++;
        if (hi !== mhi) begin failures++; $display("FAIL mtlo_busy commit hi: got %h expected %h", hi, mhi); end
    endtask

    task automatic test_reset_midop();
        run_op(MDU_MTHI, 32'h11111111, 32'd0, "pre_hi");
        @(negedge clk);
        start = 1'b1; mdu_op = MDU_MULTU; op_a = 32'd1000; op_b = 32'd1000;
        @(negedge clk);
        start = 1'b0; mdu_op = MDU_NOP;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL midreset busy: got %b expected 0", busy); end
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            failures++; $display("FAIL midreset hilo: got %h_%h expected 0", hi, lo);
        end
        @(negedge clk);
        reset = 1'b1;
        mhi = '0;
        mlo = '0;
        repeat (12) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++; $display("FAIL midreset late commit: busy=%b hi=%h lo=%h expected 0", busy, hi, lo);
        end
    endtask

    task automatic test_madd();
        run_op(MDU_MTHI, 32'd0, 32'd0, "madd_sethi");
        run_op(MDU_MTLO, 32'hFFFFFFFF, 32'd0, "madd_setlo");
        run_op(MDU_MADDU, 32'd1, 32'd1, "maddu_carry");
        run_op(MDU_MSUB, 32'd3, -32'sd4, "msub");
        run_op(MDU_MSUBU, 32'hFFFFFFFF, 32'h10, "msubu");
        run_op(MDU_MADD, -32'sd1, 32'd1, "madd");
    endtask

    task automatic test_random();
        logic [3:0] ops [13];
        logic [31:0] a, b;
        for (int i = 0; i < 13; i++) ops[i] = 4'(i);
        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                1: b = 32'd0;
                2: begin a = 32'($signed($urandom_range(0, 200)) - 100); b = 32'($signed($urandom_range(0, 20)) - 10); end
                default: ;
            endcase
            run_op(ops[$urandom_range(0, 12)], a, b, $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mt();
        test_reset_midop();
        test_madd();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
